// File: rtl/down_count_checker_if.sv
// Sample/result bundle between an upstream down counter monitor and the checker.
interface down_count_checker_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] q_in;
    logic             locked;
    logic             err;
    logic             wrap;
    logic [7:0]       err_cnt;
    logic [7:0]       wrap_cnt;

    // Driver side: supplies samples, observes checker status.
    modport master (
        output en,
        output q_in,
        input  locked,
        input  err,
        input  wrap,
        input  err_cnt,
        input  wrap_cnt
    );

    // Checker side.
    modport slave (
        input  en,
        input  q_in,
        output locked,
        output err,
        output wrap,
        output err_cnt,
        output wrap_cnt
    );
endinterface

// File: rtl/down_count_checker.sv
// Monitors a down counter: locks after LOCK_N consecutive correct decrements, then flags
// sequence errors and underflow wraps with one-cycle pulses and saturating counters.
module down_count_checker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned LOCK_N = 3
) (
    input logic                  clk,
    input logic                  rst,
    down_count_checker_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAcq, StLock} state_e;

    localparam logic [WIDTH-1:0] One   = WIDTH'(1);
    localparam logic [WIDTH-1:0] Zero  = '0;
    localparam logic [WIDTH-1:0] AllOn = '1;
    localparam logic [3:0]       LockN = 4'(LOCK_N);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       good_q, good_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;

    logic             step_ok;
    logic             step_wrap;
    logic [3:0]       good_inc;

    // Step classification against the previous accepted sample.
    always_comb begin
        step_ok   = (bus.q_in == (prev_q - One));
        step_wrap = step_ok && (prev_q == Zero) && (bus.q_in == AllOn);
        good_inc  = good_q + 4'd1;
    end

    // Next-state: acts only on qualified samples; pulses default low.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        good_d     = good_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        if (bus.en) begin
            prev_d = bus.q_in;
            unique case (state_q)
                StIdle: begin
                    // First sample only seeds prev; nothing to compare against yet.
                    good_d  = 4'd0;
                    state_d = StAcq;
                end
                StAcq: begin
                    if (step_ok) begin
                        if (good_inc == LockN) begin
                            good_d  = 4'd0;
                            state_d = StLock;
                        end else begin
                            good_d = good_inc;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end
                StLock: begin
                    if (step_ok) begin
                        if (step_wrap) begin
                            wrap_d     = 1'b1;
                            wrap_cnt_d = (wrap_cnt_q == 8'hFF) ? wrap_cnt_q : wrap_cnt_q + 8'd1;
                        end
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                        good_d    = 4'd0;
                        state_d   = StAcq;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
        locked_d = (state_d == StLock);
    end

    // State and registered outputs; reset wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            prev_q     <= '0;
            good_q     <= 4'd0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= 8'd0;
            wrap_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_q     <= good_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    // Drive the bundle from the registers.
    always_comb begin
        bus.locked   = locked_q;
        bus.err      = err_q;
        bus.wrap     = wrap_q;
        bus.err_cnt  = err_cnt_q;
        bus.wrap_cnt = wrap_cnt_q;
    end
endmodule

// File: doc/down_count_checker.md
DOWN_COUNT_CHECKER -- requirements
Module: down_count_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the width of the monitored count.
REQ-002 The block SHALL have parameter LOCK_N, default 3, the number of consecutive correct decrements needed to lock (range 1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1, sample-valid qualifier for q_in.
REQ-006 The block SHALL have port q_in, input, WIDTH, the count value from the upstream down counter.
REQ-007 The block SHALL have port locked, output, 1, high while the FSM is in LOCK.
REQ-008 The block SHALL have port err, output, 1, one-cycle pulse marking a sequence error detected in LOCK.
REQ-009 The block SHALL have port wrap, output, 1, one-cycle pulse marking a 0 -> 2^WIDTH-1 transition seen in LOCK.
REQ-010 The block SHALL have port err_cnt, output, 8, saturating count of err pulses.
REQ-011 The block SHALL have port wrap_cnt, output, 8, saturating count of wrap pulses.

Function
REQ-012 All outputs SHALL be registered; the response to a sample taken at edge N SHALL be visible immediately after edge N (1-cycle latency).
REQ-013 The block SHALL act only on edges where en=1; with en=0 the FSM state, prev, good, err_cnt and wrap_cnt SHALL hold, and err and wrap SHALL be 0.
REQ-014 A step SHALL be correct when q_in == (prev - 1) mod 2^WIDTH; so prev=0, q_in=2^WIDTH-1 is correct.
REQ-015 On every en=1 edge, prev SHALL be loaded with q_in, in every state.
REQ-016 FSM state IDLE: on en=1, capture prev, set good=0, go to ACQ; no step check on this first sample.
REQ-017 FSM state ACQ, correct step: good SHALL increment; when the incremented value equals LOCK_N, go to LOCK and clear good.
REQ-018 FSM state ACQ, incorrect step: good SHALL clear to 0 and the FSM SHALL stay in ACQ; err and err_cnt SHALL NOT change.
REQ-019 FSM state LOCK, correct step: stay in LOCK; if prev=0 and q_in=2^WIDTH-1, wrap SHALL pulse for one cycle and wrap_cnt SHALL increment.
REQ-020 FSM state LOCK, incorrect step (including q_in == prev, a repeated value): err SHALL pulse for one cycle, err_cnt SHALL increment, good SHALL clear, and the FSM SHALL go to ACQ.
REQ-021 err_cnt and wrap_cnt SHALL saturate at 255 and never wrap to 0.
REQ-022 Wraps seen in IDLE or ACQ SHALL NOT pulse wrap or change wrap_cnt.
REQ-023 err and wrap SHALL never be high in the same cycle.
REQ-024 locked SHALL equal 1 exactly in the cycles where the state is LOCK.

Reset
REQ-025 With rst=1 at an edge, after that edge: state=IDLE, prev=0, good=0, locked=0, err=0, wrap=0, err_cnt=0, wrap_cnt=0.
REQ-026 rst SHALL take priority over en at the same edge, including when asserted mid-operation while in LOCK.
REQ-027 After rst deasserts, the first en=1 sample SHALL be treated as an IDLE capture.

Verification
REQ-028 Reset, then en=1 with q_in=9,8,7,6 on consecutive edges: locked=1 after the 4th edge; err=0 throughout.
REQ-029 Locked, then q_in=1,0,15,14: wrap=1 only in the cycle after the 15 sample; wrap_cnt=1; locked stays 1.
REQ-030 Locked at prev=5, then q_in=3: err=1 for one cycle, err_cnt=1, locked=0; then q_in=2,1,0: locked=1 again.
REQ-031 Locked, en=0 for 10 cycles while q_in changes randomly: no pulses, no counter or state change; resuming with en=1 and the correct next value keeps lock.
REQ-032 Force 300 lock/error cycles: err_cnt=255 and holds there; assert rst while locked: all outputs 0 after the next edge.
